// File: rtl/reg_file_2r1w.sv
// DEPTH-entry register file: one write port, two enabled registered read ports with
// same-cycle write forwarding, optional hardwired-zero R0 and a per-register busy scoreboard.
module reg_file_2r1w #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re_a,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic              o_busy_a,
  input  logic              i_re_b,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  output logic              o_busy_b,
  input  logic              i_busy_set,
  input  logic [ADDR_W-1:0] i_busy_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_busy_a;
  logic              r_busy_b;

  logic              w_wr_ok;
  logic              w_set_ok;
  logic [DEPTH-1:0]  w_busy_d;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  assign w_wr_ok  = i_we && !(ZERO_R0 && (i_waddr == '0));
  assign w_set_ok = i_busy_set && !(ZERO_R0 && (i_busy_addr == '0));

  // Set is applied after clear so a new issue overrides the retiring write.
  always_comb begin
    w_busy_d = r_busy;
    if (i_we) begin
      w_busy_d[i_waddr] = 1'b0;
    end
    if (w_set_ok) begin
      w_busy_d[i_busy_addr] = 1'b1;
    end
  end

  always_comb begin
    w_fwd_a = r_mem[i_raddr_a];
    if (w_wr_ok && (i_waddr == i_raddr_a)) begin
      w_fwd_a = i_wdata;
    end
    if (ZERO_R0 && (i_raddr_a == '0)) begin
      w_fwd_a = '0;
    end
  end

  always_comb begin
    w_fwd_b = r_mem[i_raddr_b];
    if (w_wr_ok && (i_waddr == i_raddr_b)) begin
      w_fwd_b = i_wdata;
    end
    if (ZERO_R0 && (i_raddr_b == '0)) begin
      w_fwd_b = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy    <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_busy_a  <= 1'b0;
      r_busy_b  <= 1'b0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy    <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_busy_a  <= 1'b0;
      r_busy_b  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[i_waddr] <= i_wdata;
      end
      r_busy <= w_busy_d;
      if (i_re_a) begin
        r_rdata_a <= w_fwd_a;
        r_busy_a  <= w_busy_d[i_raddr_a];
      end
      if (i_re_b) begin
        r_rdata_b <= w_fwd_b;
        r_busy_b  <= w_busy_d[i_raddr_b];
      end
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;
  assign o_busy_a  = r_busy_a;
  assign o_busy_b  = r_busy_b;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: default, ZERO_R0=0 and 16x16 instances share stimulus.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        re_a = 1'b0;
  logic [3:0]  raddr_a = '0;
  logic        re_b = 1'b0;
  logic [3:0]  raddr_b = '0;
  logic        busy_set = 1'b0;
  logic [3:0]  busy_addr = '0;

  logic [7:0]  u0_rdata_a, u0_rdata_b, u1_rdata_a, u1_rdata_b;
  logic [15:0] u2_rdata_a, u2_rdata_b;
  logic        u0_busy_a, u0_busy_b, u1_busy_a, u1_busy_b, u2_busy_a, u2_busy_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    int          sel;
    bit          chk_a;
    logic [15:0] da;
    logic        ba;
    bit          chk_b;
    logic [15:0] db;
    logic        bb;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  reg_file_2r1w u0 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_we(we), .i_waddr(waddr[2:0]),
    .i_wdata(wdata[7:0]), .i_re_a(re_a), .i_raddr_a(raddr_a[2:0]), .o_rdata_a(u0_rdata_a),
    .o_busy_a(u0_busy_a), .i_re_b(re_b), .i_raddr_b(raddr_b[2:0]), .o_rdata_b(u0_rdata_b),
    .o_busy_b(u0_busy_b), .i_busy_set(busy_set), .i_busy_addr(busy_addr[2:0])
  );

  reg_file_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(1'b0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_we(we), .i_waddr(waddr[2:0]),
    .i_wdata(wdata[7:0]), .i_re_a(re_a), .i_raddr_a(raddr_a[2:0]), .o_rdata_a(u1_rdata_a),
    .o_busy_a(u1_busy_a), .i_re_b(re_b), .i_raddr_b(raddr_b[2:0]), .o_rdata_b(u1_rdata_b),
    .o_busy_b(u1_busy_b), .i_busy_set(busy_set), .i_busy_addr(busy_addr[2:0])
  );

  reg_file_2r1w #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_re_a(re_a), .i_raddr_a(raddr_a), .o_rdata_a(u2_rdata_a),
    .o_busy_a(u2_busy_a), .i_re_b(re_b), .i_raddr_b(raddr_b), .o_rdata_b(u2_rdata_b),
    .o_busy_b(u2_busy_b), .i_busy_set(busy_set), .i_busy_addr(busy_addr)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expectation applies to the outputs after the next rising edge.
  task automatic expect_rd(input int sel, input bit ca, input logic [15:0] da, input logic ba,
                           input bit cb, input logic [15:0] db, input logic bb,
                           input string name);
    exp_t x;
    x.cyc = cyc + 1; x.sel = sel; x.name = name;
    x.chk_a = ca; x.da = da; x.ba = ba;
    x.chk_b = cb; x.db = db; x.bb = bb;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0: begin
          if (e.chk_a) begin
            check({e.name, " u0 rdata_a"}, {8'h00, u0_rdata_a}, e.da);
            check({e.name, " u0 busy_a"}, {15'h0, u0_busy_a}, {15'h0, e.ba});
          end
          if (e.chk_b) begin
            check({e.name, " u0 rdata_b"}, {8'h00, u0_rdata_b}, e.db);
            check({e.name, " u0 busy_b"}, {15'h0, u0_busy_b}, {15'h0, e.bb});
          end
        end
        1: begin
          if (e.chk_a) begin
            check({e.name, " u1 rdata_a"}, {8'h00, u1_rdata_a}, e.da);
            check({e.name, " u1 busy_a"}, {15'h0, u1_busy_a}, {15'h0, e.ba});
          end
          if (e.chk_b) begin
            check({e.name, " u1 rdata_b"}, {8'h00, u1_rdata_b}, e.db);
            check({e.name, " u1 busy_b"}, {15'h0, u1_busy_b}, {15'h0, e.bb});
          end
        end
        default: begin
          if (e.chk_a) begin
            check({e.name, " u2 rdata_a"}, u2_rdata_a, e.da);
            check({e.name, " u2 busy_a"}, {15'h0, u2_busy_a}, {15'h0, e.ba});
          end
          if (e.chk_b) begin
            check({e.name, " u2 rdata_b"}, u2_rdata_b, e.db);
            check({e.name, " u2 busy_b"}, {15'h0, u2_busy_b}, {15'h0, e.bb});
          end
        end
      endcase
    end
  end

  // Advance one edge, then return just after the following falling edge with inputs idle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; wdata = d;
  endtask

  task automatic rd_a(input logic [3:0] a);
    re_a = 1'b1; raddr_a = a;
  endtask

  task automatic rd_b(input logic [3:0] a);
    re_b = 1'b1; raddr_b = a;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset u0 rdata_a", {8'h00, u0_rdata_a}, 16'h0000);
    check("reset u0 busy_b", {15'h0, u0_busy_b}, 16'h0000);
    check("reset u2 rdata_b", u2_rdata_b, 16'h0000);
    rst = 1'b1;
    tick();

    // Reset path
    wr(3, 16'h00A5); tick();
    rd_a(3); expect_rd(0, 1, 16'h00A5, 0, 0, 0, 0, "write R3"); tick();
    rst = 1'b0;
    #1;
    check("async reset rdata_a", {8'h00, u0_rdata_a}, 16'h0000);
    @(negedge clk); #1;
    rst = 1'b1;
    tick();
    rd_a(3); expect_rd(0, 1, 16'h0000, 0, 0, 0, 0, "R3 after reset"); tick();

    // Clear path, overriding a write and a read in the same cycle
    wr(3, 16'h00A5); tick();
    rd_a(3); expect_rd(0, 1, 16'h00A5, 0, 0, 0, 0, "rewrite R3"); tick();
    clr = 1'b1; wr(3, 16'h0099); rd_a(3); busy_set = 1'b1; busy_addr = 3;
    expect_rd(0, 1, 16'h0000, 0, 0, 0, 0, "clr edge"); tick();
    rd_a(3); expect_rd(0, 1, 16'h0000, 0, 0, 0, 0, "R3 after clr"); tick();

    // Forwarding
    wr(5, 16'h0011); tick();
    wr(5, 16'h0022); rd_a(5); rd_b(5);
    expect_rd(0, 1, 16'h0022, 0, 1, 16'h0022, 0, "forward R5"); tick();
    rd_a(5); rd_b(5);
    expect_rd(0, 1, 16'h0022, 0, 1, 16'h0022, 0, "R5 next edge"); tick();

    // Hold while disabled
    wr(2, 16'h003C); tick();
    rd_a(2); expect_rd(0, 1, 16'h003C, 0, 0, 0, 0, "read R2"); tick();
    wr(2, 16'h0099); expect_rd(0, 1, 16'h003C, 0, 0, 0, 0, "hold R2"); tick();
    rd_a(2); expect_rd(0, 1, 16'h0099, 0, 0, 0, 0, "reenable R2"); tick();

    // Zero register
    wr(0, 16'h00FF); busy_set = 1'b1; busy_addr = 0; tick();
    rd_a(0); rd_b(0);
    expect_rd(0, 1, 16'h0000, 0, 1, 16'h0000, 0, "zero R0");
    expect_rd(1, 1, 16'h00FF, 1, 0, 0, 0, "plain R0"); tick();

    // Busy scoreboard
    busy_set = 1'b1; busy_addr = 4; tick();
    rd_a(4); expect_rd(0, 1, 16'h0000, 1, 0, 0, 0, "busy R4"); tick();
    wr(4, 16'h0007); busy_set = 1'b1; busy_addr = 4; rd_a(4);
    expect_rd(0, 1, 16'h0007, 1, 0, 0, 0, "set beats clear R4"); tick();
    rd_a(4); expect_rd(0, 1, 16'h0007, 1, 0, 0, 0, "R4 still busy"); tick();
    wr(4, 16'h0008); rd_a(4);
    expect_rd(0, 1, 16'h0008, 0, 0, 0, 0, "write retires R4"); tick();
    busy_set = 1'b1; busy_addr = 6; rd_b(6); rd_a(4);
    expect_rd(0, 1, 16'h0008, 0, 1, 16'h0000, 1, "same-edge busy R6"); tick();

    // Wide instance: fill all 16 registers, read back pairwise
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'h1234 + 16'(i) * 16'h0101); tick();
    end
    for (int i = 0; i < 8; i++) begin
      rd_a(4'(i)); rd_b(4'(15 - i));
      expect_rd(2, 1, 16'h1234 + 16'(i) * 16'h0101, 0,
                1, 16'h1234 + 16'(15 - i) * 16'h0101, 0, "wide pair");
      tick();
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file for the processor datapath: one write port, two independently enabled read ports with registered outputs, and a per-register busy scoreboard. It generalises the single 8-bit enable register into a DEPTH-entry array. It adds same-cycle write-to-read forwarding, an optional hardwired-zero R0, and a synchronous clear. It sits between decode (read/issue) and writeback (write) stages.

## Interface
- DATA_W, default 8: width of each register and of the data ports.
- ADDR_W, default 3: address width; DEPTH = 2**ADDR_W entries.
- ZERO_R0, default 1: when 1, register 0 always reads 0, ignores writes and never becomes busy.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear of all registers, busy bits and read outputs.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re_a  in  1  read enable, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- busy_a  out  1  registered busy status of raddr_a.
- re_b, raddr_b, rdata_b, busy_b: same as port A, for port B.
- busy_set  in  1  mark busy_addr as having a pending write.
- busy_addr  in  ADDR_W  register to mark busy.

## Operation
- **Reset.** rst=0 asynchronously clears all DEPTH registers, all busy bits, rdata_a/b and busy_a/b to 0. Reset mid-operation discards any pending write or busy_set.
- **Clear.** clr=1 at a clock edge has the same effect as reset, synchronously. It overrides we, busy_set, re_a and re_b in that cycle.
- **Write.** When we=1 and clr=0, mem[waddr] <= wdata at the edge. If ZERO_R0=1 and waddr=0, the write is dropped.
- **Read, per port x.**
  - When re_x=1 and clr=0, rdata_x <= the forwarded value of raddr_x at the edge.
  - The forwarded value is wdata if we=1 and waddr=raddr_x (and the write is not dropped). Otherwise it is mem[raddr_x].
  - When ZERO_R0=1 and raddr_x=0, the result is 0.
  - When re_x=0, rdata_x and busy_x hold their values.
- **Busy scoreboard.** There is one bit per register.
  - busy_set=1 sets bit busy_addr.
  - we=1 clears bit waddr.
  - If both target the same address in the same cycle, set wins: a new issue overrides the retiring write.
  - busy_set to R0 with ZERO_R0=1 is ignored.
- **busy_x.** busy_x <= next-state busy bit of raddr_x, registered together with rdata_x under re_x. This is the bit after this cycle's set/clear is applied.
- **Port independence.** Ports A and B are fully independent and may read the same address in the same cycle.
- **Width.** Data is not extended, truncated or sign-handled; addresses are always in range (DEPTH = 2**ADDR_W).

## Timing
- Read latency: 1 cycle. Address and re_x are presented at edge N; data is valid after edge N and stays valid until the next enabled read or clr.
- Write latency: stored at edge N. A read issued at the same edge N returns the new data via forwarding. There is no stale-read cycle.
- Busy latency: busy_set at edge N is visible to a read issued at edge N (busy_x=1 after N). A write at edge N makes busy_x=0 for a read issued at N, unless busy_set targets the same address at N.
- There is no handshake and no stall. Every input is sampled on every edge; there is no combinational path from inputs to outputs.
- Priority at an edge: rst (asynchronous), then clr, then normal operation. Within normal operation, busy_set has priority over the write's busy-clear for the same address.

## Test plan
- **Reset/clear.**
  - Write 8'hA5 to R3; read port A from R3 → rdata_a=8'hA5.
  - Pulse rst low → rdata_a=0 immediately, and a subsequent read of R3 returns 0.
  - Repeat using clr=1 for one cycle → same result, synchronously.
- **Forwarding.**
  - R5 holds 8'h11. At the same edge, write 8'h22 to R5 and read R5 on both ports → rdata_a=rdata_b=8'h22 after that edge.
  - A read of R5 at the next edge still returns 8'h22.
- **Hold/enable.**
  - Read R2 (8'h3C) on port A, then set re_a=0 and write 8'h99 to R2 → rdata_a stays 8'h3C.
  - Set re_a=1 → rdata_a=8'h99.
- **Zero register (ZERO_R0=1).**
  - Write 8'hFF to R0 with busy_set to R0; read R0 → rdata=0, busy=0.
  - With ZERO_R0=0, the same sequence → rdata=8'hFF.
- **Scoreboard.**
  - busy_set R4; read R4 → busy_a=1.
  - Write R4 (8'h07) at the same edge as a new busy_set R4; read → rdata=8'h07, busy=1.
  - Write R4 again with no set; read → busy=0.
- **Parametrisation.** With DATA_W=16 and ADDR_W=4: write a distinct value to all 16 registers, then read them pairwise on A/B → every value matches, and R15 wraps nothing.
